// File: rtl/vsm_pkg.sv
// Shared types for the VSM micro-sequencer: opcodes, machine phases and the
// control-strobe bundle driven into the datapath.
package vsm_pkg;

  localparam logic [3:0] OP_NOP  = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_SUB  = 4'b0010;
  localparam logic [3:0] OP_OUT  = 4'b0011;
  localparam logic [3:0] OP_IN   = 4'b0100;
  localparam logic [3:0] OP_LOAD = 4'b0101;

  typedef enum logic [2:0] {
    P0,
    P1,
    P2,
    P3,
    IDLE
  } phase_e;

  typedef struct packed {
    logic load_inst;
    logic read_mem;
    logic prog_count;
    logic enable_instr;
    logic enable_in;
    logic enable_a;
    logic enable_alu;
    logic load_a;
    logic load_b;
    logic load_out;
    logic add_sub;
  } ctrl_t;

  // IDLE has no phase bit of its own so it maps to all zeros.
  function automatic logic [3:0] phase_onehot(input phase_e p);
    logic [3:0] oh;
    case (p)
      P0:      oh = 4'b0001;
      P1:      oh = 4'b0010;
      P2:      oh = 4'b0100;
      P3:      oh = 4'b1000;
      default: oh = 4'b0000;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/vsm_micro_sequencer_if.sv
// Handshake bundle between the instruction register / run control and the
// sequencer's registered datapath strobes.
interface vsm_micro_sequencer_if;

  logic       run;
  logic [3:0] instr_in;
  logic [3:0] phase;
  logic       load_inst;
  logic       read_mem;
  logic       prog_count;
  logic       enable_instr;
  logic       enable_in;
  logic       enable_a;
  logic       enable_alu;
  logic       load_a;
  logic       load_b;
  logic       load_out;
  logic       add_sub;
  logic       illegal;

  modport master (
    output run, instr_in,
    input  phase, load_inst, read_mem, prog_count, enable_instr, enable_in,
           enable_a, enable_alu, load_a, load_b, load_out, add_sub, illegal
  );

  modport slave (
    input  run, instr_in,
    output phase, load_inst, read_mem, prog_count, enable_instr, enable_in,
           enable_a, enable_alu, load_a, load_b, load_out, add_sub, illegal
  );

endinterface

// File: rtl/vsm_op_decode.sv
// Combinational control-word decode for one machine phase and opcode.
// Fetch phases ignore the opcode; execute phases flag anything undecoded.
module vsm_op_decode
  import vsm_pkg::*;
(
  input  phase_e     phase_i,
  input  logic [3:0] opcode_i,
  output ctrl_t      ctrl_o,
  output logic       illegal_o
);

  always_comb begin
    ctrl_o    = '0;
    illegal_o = 1'b0;
    case (phase_i)
      P0: begin
        ctrl_o.load_inst = 1'b1;
        ctrl_o.read_mem  = 1'b1;
      end
      P1: begin
        ctrl_o.prog_count   = 1'b1;
        ctrl_o.enable_instr = 1'b1;
      end
      P2: begin
        case (opcode_i)
          OP_NOP:  ctrl_o.read_mem = 1'b1;
          OP_ADD: begin
            ctrl_o.load_b       = 1'b1;
            ctrl_o.enable_instr = 1'b1;
          end
          OP_SUB: begin
            ctrl_o.load_b       = 1'b1;
            ctrl_o.enable_instr = 1'b1;
            ctrl_o.add_sub      = 1'b1;
          end
          OP_OUT: begin
            ctrl_o.enable_a = 1'b1;
            ctrl_o.load_out = 1'b1;
          end
          OP_IN: begin
            ctrl_o.enable_in = 1'b1;
            ctrl_o.load_a    = 1'b1;
          end
          OP_LOAD: begin
            ctrl_o.load_a       = 1'b1;
            ctrl_o.enable_instr = 1'b1;
          end
          default: illegal_o = 1'b1;
        endcase
      end
      P3: begin
        case (opcode_i)
          OP_ADD: begin
            ctrl_o.enable_alu = 1'b1;
            ctrl_o.load_a     = 1'b1;
          end
          OP_SUB: begin
            ctrl_o.enable_alu = 1'b1;
            ctrl_o.load_a     = 1'b1;
            ctrl_o.add_sub    = 1'b1;
          end
          OP_NOP, OP_OUT, OP_IN, OP_LOAD: ;
          default: illegal_o = 1'b1;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/vsm_micro_sequencer.sv
// VSM CPU micro-sequencer: 4-phase machine-cycle counter plus registered
// control strobes describing the phase just entered.
module vsm_micro_sequencer
  import vsm_pkg::*;
(
  input logic            clk,
  input logic            rst,
  vsm_micro_sequencer_if.slave bus
);

  phase_e phase_q, phase_d;
  ctrl_t  ctrl_q, ctrl_d, dec_ctrl;
  logic   illegal_q, illegal_d, dec_illegal;

  // Decode looks ahead at the phase about to be entered so strobes are registered.
  vsm_op_decode u_decode (
    .phase_i   (phase_d),
    .opcode_i  (bus.instr_in),
    .ctrl_o    (dec_ctrl),
    .illegal_o (dec_illegal)
  );

  always_comb begin
    phase_d   = phase_q;
    ctrl_d    = ctrl_q;
    illegal_d = illegal_q;
    if (bus.run) begin
      case (phase_q)
        P0:      phase_d = P1;
        P1:      phase_d = P2;
        P2:      phase_d = P3;
        default: phase_d = P0;
      endcase
      ctrl_d    = dec_ctrl;
      illegal_d = dec_illegal;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q   <= IDLE;
      ctrl_q    <= '0;
      illegal_q <= 1'b0;
    end else begin
      phase_q   <= phase_d;
      ctrl_q    <= ctrl_d;
      illegal_q <= illegal_d;
    end
  end

  assign bus.phase        = phase_onehot(phase_q);
  assign bus.load_inst    = ctrl_q.load_inst;
  assign bus.read_mem     = ctrl_q.read_mem;
  assign bus.prog_count   = ctrl_q.prog_count;
  assign bus.enable_instr = ctrl_q.enable_instr;
  assign bus.enable_in    = ctrl_q.enable_in;
  assign bus.enable_a     = ctrl_q.enable_a;
  assign bus.enable_alu   = ctrl_q.enable_alu;
  assign bus.load_a       = ctrl_q.load_a;
  assign bus.load_b       = ctrl_q.load_b;
  assign bus.load_out     = ctrl_q.load_out;
  assign bus.add_sub      = ctrl_q.add_sub;
  assign bus.illegal      = illegal_q;

endmodule

// File: tb/tb_vsm_micro_sequencer.sv
// Directed bench for vsm_micro_sequencer: a phase/opcode table model checked
// every negedge, plus literal spot checks of the documented scenarios.
module tb_vsm_micro_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  vsm_micro_sequencer_if bus ();

  vsm_micro_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Word layout: {load_inst, read_mem, prog_count, enable_instr, enable_in,
  //               enable_a, enable_alu, load_a, load_b, load_out, add_sub, illegal}
  localparam logic [11:0] W_LI   = 12'h800;
  localparam logic [11:0] W_RM   = 12'h400;
  localparam logic [11:0] W_PC   = 12'h200;
  localparam logic [11:0] W_EI   = 12'h100;
  localparam logic [11:0] W_EN   = 12'h080;
  localparam logic [11:0] W_EA   = 12'h040;
  localparam logic [11:0] W_EALU = 12'h020;
  localparam logic [11:0] W_LA   = 12'h010;
  localparam logic [11:0] W_LB   = 12'h008;
  localparam logic [11:0] W_LO   = 12'h004;
  localparam logic [11:0] W_AS   = 12'h002;
  localparam logic [11:0] W_ILL  = 12'h001;

  int n_cmp = 0;
  int n_bad = 0;

  int         m_ph = -1;   // -1 = idle, else phase number 0..3
  logic [3:0] m_op = 4'd0;

  function automatic logic [11:0] exp_word(input int ph, input logic [3:0] op);
    logic [11:0] w;
    w = 12'h000;
    if (ph == 0)      w = W_LI | W_RM;
    else if (ph == 1) w = W_PC | W_EI;
    else if (ph == 2 || ph == 3) begin
      case (op)
        4'd0: w = (ph == 2) ? W_RM : 12'h000;
        4'd1: w = (ph == 2) ? (W_LB | W_EI) : (W_EALU | W_LA);
        4'd2: w = (ph == 2) ? (W_LB | W_EI | W_AS) : (W_EALU | W_LA | W_AS);
        4'd3: w = (ph == 2) ? (W_EA | W_LO) : 12'h000;
        4'd4: w = (ph == 2) ? (W_EN | W_LA) : 12'h000;
        4'd5: w = (ph == 2) ? (W_LA | W_EI) : 12'h000;
        default: w = W_ILL;
      endcase
    end
    return w;
  endfunction

  function automatic logic [3:0] exp_phase(input int ph);
    logic [3:0] one;
    one = 4'b0001;
    return (ph < 0) ? 4'b0000 : (one << ph);
  endfunction

  function automatic logic [11:0] got_word();
    return {bus.load_inst, bus.read_mem, bus.prog_count, bus.enable_instr,
            bus.enable_in, bus.enable_a, bus.enable_alu, bus.load_a,
            bus.load_b, bus.load_out, bus.add_sub, bus.illegal};
  endfunction

  task automatic chk(input string name, input logic [11:0] got, input logic [11:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("model_phase", {8'h00, bus.phase}, {8'h00, exp_phase(m_ph)});
    chk("model_word", got_word(), exp_word(m_ph, m_op));
    chk("one_bus_driver",
        12'(int'(bus.enable_instr) + int'(bus.enable_in) + int'(bus.enable_a) + int'(bus.enable_alu) > 1),
        12'h000);
  end

  task automatic step(input logic r, input logic [3:0] op);
    bus.run      = r;
    bus.instr_in = op;
    @(posedge clk);
    #1;
    if (r) begin
      m_ph = (m_ph < 0) ? 0 : (m_ph + 1) % 4;
      if (m_ph >= 2) m_op = op;
    end
  endtask

  task automatic lit(input string name, input logic got, input logic want);
    chk(name, {11'h000, got}, {11'h000, want});
  endtask

  logic [3:0] held_phase;
  logic [11:0] held_word;

  initial begin
    bus.run      = 1'b0;
    bus.instr_in = 4'd0;
    #12 rst = 1'b0;
    chk("reset_phase", {8'h00, bus.phase}, 12'h000);
    chk("reset_word", got_word(), 12'h000);

    // ADD through one machine cycle
    step(1'b1, 4'b0001);
    chk("add_p0_phase", {8'h00, bus.phase}, 12'h001);
    lit("add_p0_load_inst", bus.load_inst, 1'b1);
    step(1'b1, 4'b0001);
    chk("add_p1_phase", {8'h00, bus.phase}, 12'h002);
    step(1'b1, 4'b0001);
    chk("add_p2_phase", {8'h00, bus.phase}, 12'h004);
    lit("add_p2_load_b", bus.load_b, 1'b1);
    lit("add_p2_enable_instr", bus.enable_instr, 1'b1);
    step(1'b1, 4'b0001);
    chk("add_p3_phase", {8'h00, bus.phase}, 12'h008);
    lit("add_p3_enable_alu", bus.enable_alu, 1'b1);
    lit("add_p3_load_a", bus.load_a, 1'b1);
    lit("add_p3_add_sub", bus.add_sub, 1'b0);

    // SUB
    step(1'b1, 4'b0010);
    step(1'b1, 4'b0010);
    step(1'b1, 4'b0010);
    lit("sub_p2_add_sub", bus.add_sub, 1'b1);
    lit("sub_p2_load_b", bus.load_b, 1'b1);
    lit("sub_p2_load_a", bus.load_a, 1'b0);
    step(1'b1, 4'b0010);
    lit("sub_p3_add_sub", bus.add_sub, 1'b1);
    lit("sub_p3_load_b", bus.load_b, 1'b0);
    lit("sub_p3_load_a", bus.load_a, 1'b1);

    // OUT, IN, LOAD, NOP sweep
    begin
      logic [3:0]  ops  [4] = '{4'b0011, 4'b0100, 4'b0101, 4'b0000};
      logic [11:0] p2w  [4] = '{12'h044, 12'h090, 12'h110, 12'h400};
      for (int i = 0; i < 4; i++) begin
        step(1'b1, ops[i]);
        step(1'b1, ops[i]);
        step(1'b1, ops[i]);
        chk("sweep_p2_word", got_word(), p2w[i]);
        step(1'b1, ops[i]);
        chk("sweep_p3_word", got_word(), 12'h000);
      end
    end

    // Illegal opcode
    step(1'b1, 4'b0000);
    step(1'b1, 4'b0000);
    step(1'b1, 4'b1010);
    chk("illegal_p2_word", got_word(), 12'h001);
    step(1'b1, 4'b1010);
    lit("illegal_p3", bus.illegal, 1'b1);
    step(1'b1, 4'b1010);
    lit("illegal_p0_clear", bus.illegal, 1'b0);
    lit("illegal_p0_load_inst", bus.load_inst, 1'b1);
    lit("illegal_p0_read_mem", bus.read_mem, 1'b1);

    // Hold in P2 with run=0 while instr_in wanders
    step(1'b1, 4'b0001);
    step(1'b1, 4'b0001);
    held_phase = bus.phase;
    held_word  = got_word();
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 4'(4'd6 + i));
      chk("hold_phase", {8'h00, bus.phase}, 12'h004);
      chk("hold_word", got_word(), 12'h108);
    end
    step(1'b1, 4'b0010);
    chk("hold_resume_phase", {8'h00, bus.phase}, 12'h008);
    chk("hold_resume_word", got_word(), 12'h032);

    // Async reset while in P3
    step(1'b1, 4'b0001);
    step(1'b1, 4'b0001);
    step(1'b1, 4'b0001);
    step(1'b1, 4'b0001);
    chk("pre_rst_phase", {8'h00, bus.phase}, 12'h008);
    #2 rst = 1'b1;
    m_ph = -1;
    #1;
    chk("async_rst_phase", {8'h00, bus.phase}, 12'h000);
    chk("async_rst_word", got_word(), 12'h000);
    rst = 1'b0;
    step(1'b1, 4'b0001);
    chk("post_rst_phase", {8'h00, bus.phase}, 12'h001);
    chk("post_rst_word", got_word(), 12'hC00);

    step(1'b0, 4'b0000);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
